// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame controller.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4,
    S_HOLD = 3'd5
  } state_t;

  localparam logic [7:0] HDR_DEFAULT = 8'hAA;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int addr_w(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte idle timer: clearable counter with enable and a terminal-count flag.
module uart_frame_timer #(
  parameter int  TIMEOUT_CYC = 50000,
  localparam int CNT_W       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1
) (
  input  logic clk_50,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  // o_tc marks the cycle whose increment would bring the count to TIMEOUT_CYC-1
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 2);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc = i_en & ~i_clr & (r_cnt == LAST);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Parses the UART byte stream into HDR/CMD/LEN/payload/CHK frames and holds
// each checked frame for the application until it is acknowledged.
//
// state  | meaning
// IDLE   | hunting for the header byte
// CMD    | waiting for the command byte
// LEN    | waiting for the payload length byte
// DATA   | storing payload bytes into the buffer
// CHK    | comparing the checksum byte
// HOLD   | good frame presented, waiting for frame_ack
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int          MAX_LEN     = 16,
  parameter int          TIMEOUT_CYC = 50000,
  parameter logic [7:0]  HDR         = HDR_DEFAULT,
  localparam int         LEN_W       = len_w(MAX_LEN),
  localparam int         ADDR_W      = addr_w(MAX_LEN)
) (
  input  logic              clk_50,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic [7:0]        frame_cmd,
  output logic [LEN_W-1:0]  frame_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              err_chk,
  output logic              err_len,
  output logic              err_timeout,
  output logic              err_overrun
);

  state_t            r_state;
  logic [7:0]        r_cmd;
  logic [LEN_W-1:0]  r_len;
  logic [7:0]        r_chk;
  logic [ADDR_W-1:0] r_idx;
  logic [7:0]        r_buf [MAX_LEN];
  logic              r_err_chk;
  logic              r_err_len;
  logic              r_err_timeout;
  logic              r_err_overrun;

  logic w_in_frame;
  logic w_tc;
  logic w_last;
  logic w_len_bad;
  logic w_hdr;

  assign w_in_frame = (r_state == S_CMD) || (r_state == S_LEN) ||
                      (r_state == S_DATA) || (r_state == S_CHK);
  assign w_last     = (LEN_W'(r_idx) == (r_len - LEN_W'(1)));
  assign w_len_bad  = (rx_data > 8'(MAX_LEN));
  assign w_hdr      = rx_valid && (rx_data == HDR);

  uart_frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .i_en   (w_in_frame),
    .i_clr  (rx_valid),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cmd         <= '0;
      r_len         <= '0;
      r_chk         <= '0;
      r_idx         <= '0;
      r_err_chk     <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_err_chk     <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;
      if (w_tc) begin
        r_err_timeout <= 1'b1;
        r_state       <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (w_hdr) begin
            r_state <= S_CMD;
            r_chk   <= '0;
            r_idx   <= '0;
          end
          S_CMD: if (rx_valid) begin
            r_cmd   <= rx_data;
            r_chk   <= r_chk + rx_data;
            r_state <= S_LEN;
          end
          S_LEN: if (rx_valid) begin
            if (w_len_bad) begin
              r_err_len <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_len   <= LEN_W'(rx_data);
              r_chk   <= r_chk + rx_data;
              r_state <= (rx_data == 8'd0) ? S_CHK : S_DATA;
            end
          end
          S_DATA: if (rx_valid) begin
            r_chk <= r_chk + rx_data;
            r_idx <= r_idx + ADDR_W'(1);
            if (w_last) r_state <= S_CHK;
          end
          S_CHK: if (rx_valid) begin
            if (rx_data == r_chk) begin
              r_state <= S_HOLD;
            end else begin
              r_err_chk <= 1'b1;
              r_state   <= S_IDLE;
            end
          end
          S_HOLD: begin
            // an ack releases the frame and the same-cycle byte is seen as if in IDLE
            if (frame_ack) begin
              if (w_hdr) begin
                r_state <= S_CMD;
                r_chk   <= '0;
                r_idx   <= '0;
              end else begin
                r_state <= S_IDLE;
              end
            end else if (rx_valid) begin
              r_err_overrun <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if ((r_state == S_DATA) && rx_valid) r_buf[r_idx] <= rx_data;
  end

  assign rd_data     = r_buf[rd_addr];
  assign frame_valid = (r_state == S_HOLD);
  assign busy        = (r_state != S_IDLE);
  assign frame_cmd   = r_cmd;
  assign frame_len   = r_len;
  assign err_chk     = r_err_chk;
  assign err_len     = r_err_len;
  assign err_timeout = r_err_timeout;
  assign err_overrun = r_err_overrun;

endmodule
